// File: rtl/sobel_pkg.sv
// Shared constants, types and helpers for the Sobel edge detector.
package sobel_pkg;

    localparam int unsigned MODE_GREY = 0;
    localparam int unsigned MODE_MAX  = 1;
    localparam int unsigned SOBEL_LAT = 4;
    localparam int unsigned ROW_W     = 11;

    typedef struct packed {
        logic valid;
        logic hsync;
        logic vsync;
    } sobel_qual_t;

    // L1 of 8*(2^dw-1) needs three extra bits
    function automatic int unsigned mag_width(input int unsigned data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line RAM delay line; registered taps give the pixel one line (taps1x)
// and two lines (taps0x) above the pixel being written.
module sobel_line_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] taps1x,
    output logic [DATA_WIDTH-1:0] taps0x
);

    localparam int unsigned PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] mem1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] mem0 [IMG_WIDTH];
    logic [PTR_W-1:0]      ptr;

    // Pointer and taps; clr realigns the pointer to column 0 between lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            taps1x <= '0;
            taps0x <= '0;
        end else if (clr) begin
            ptr    <= '0;
            taps1x <= '0;
            taps0x <= '0;
        end else if (we) begin
            taps1x <= mem1[ptr];
            taps0x <= mem0[ptr];
            ptr    <= (ptr == PTR_W'(IMG_WIDTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    // Storage: the older line cascades from mem1 into mem0 at the same address
    always_ff @(posedge clk) begin
        if (we) begin
            mem1[ptr] <= din;
            mem0[ptr] <= mem1[ptr];
        end
    end

endmodule

// File: rtl/sobel_edge_ext.sv
// Sobel edge detector: 3x3 window from a sync'd pixel stream, |Gx|/|Gy|,
// L1 or max norm, then binary threshold or saturated grey output.
module sobel_edge_ext
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned IMG_WIDTH         = 640,
    parameter int unsigned DEFAULT_THRESHOLD = 50
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_hsync,
    input  logic                  din_vsync,
    input  logic [DATA_WIDTH+2:0] threshold,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] edge_out,
    output logic                  edge_valid,
    output logic                  edge_hsync,
    output logic                  edge_vsync
);

    localparam int unsigned MAG_W  = mag_width(DATA_WIDTH);
    localparam int unsigned GRAD_W = DATA_WIDTH + 2;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    function automatic logic [GRAD_W-1:0] abs_diff(input logic [GRAD_W-1:0] a,
                                                   input logic [GRAD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic                  armed;
    logic                  pix_q;
    logic                  border;
    logic [COL_W-1:0]      col_cnt;
    logic [ROW_W-1:0]      row_cnt;
    logic [MAG_W-1:0]      thr_lat;
    logic [1:0]            mode_lat;
    logic [DATA_WIDTH-1:0] taps1x;
    logic [DATA_WIDTH-1:0] taps0x;
    logic [DATA_WIDTH-1:0] win [3][2];
    logic [DATA_WIDTH-1:0] pix_new;
    logic [DATA_WIDTH-1:0] p [3][3];
    logic [GRAD_W-1:0]     gx_pos, gx_neg, gy_pos, gy_neg;
    logic                  s0_border, s1_border, s2_border;
    logic [MAG_W-1:0]      s0_thr, s1_thr, s2_thr;
    logic [1:0]            s0_mode, s1_mode;
    logic                  s2_grey;
    logic [GRAD_W-1:0]     s1_gx, s1_gy;
    logic [MAG_W-1:0]      s2_mag;
    logic [DATA_WIDTH-1:0] result;
    sobel_qual_t           qd [SOBEL_LAT];

    // After a reset the stream is ignored until the next inter-frame gap
    assign pix_q  = din_valid && din_hsync && din_vsync && armed;
    assign border = !armed || (col_cnt < COL_W'(2)) || (row_cnt < ROW_W'(2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            thr_lat  <= MAG_W'(DEFAULT_THRESHOLD);
            mode_lat <= '0;
        end else if (!din_vsync) begin
            armed    <= 1'b1;
            thr_lat  <= threshold;
            mode_lat <= mode;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (!din_hsync) begin
                col_cnt <= '0;
            end else if (pix_q && col_cnt != COL_W'(IMG_WIDTH - 1)) begin
                col_cnt <= col_cnt + COL_W'(1);
            end
            if (!din_vsync) begin
                row_cnt <= '0;
            end else if (pix_q && col_cnt == COL_W'(IMG_WIDTH - 1) && row_cnt != '1) begin
                row_cnt <= row_cnt + ROW_W'(1);
            end
        end
    end

    sobel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_line_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (pix_q),
        .clr     (!din_hsync),
        .din     (din),
        .taps1x  (taps1x),
        .taps0x  (taps0x)
    );

    // Full 3x3 view; the newest column lives in the line-buffer taps and pix_new
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win[r][0];
            p[r][1] = win[r][1];
        end
        p[0][2] = taps0x;
        p[1][2] = taps1x;
        p[2][2] = pix_new;
    end

    // S0: window load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
            pix_new <= '0;
        end else if (!din_hsync) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
            pix_new <= '0;
        end else if (pix_q) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= p[r][2];
            end
            pix_new <= din;
        end
    end

    always_comb begin
        gx_pos = GRAD_W'(p[0][2]) + (GRAD_W'(p[1][2]) << 1) + GRAD_W'(p[2][2]);
        gx_neg = GRAD_W'(p[0][0]) + (GRAD_W'(p[1][0]) << 1) + GRAD_W'(p[2][0]);
        gy_pos = GRAD_W'(p[2][0]) + (GRAD_W'(p[2][1]) << 1) + GRAD_W'(p[2][2]);
        gy_neg = GRAD_W'(p[0][0]) + (GRAD_W'(p[0][1]) << 1) + GRAD_W'(p[0][2]);
    end

    // S1..S2: gradients, then norm; frame settings travel with each pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_border <= 1'b1;
            s0_thr    <= '0;
            s0_mode   <= '0;
            s1_border <= 1'b1;
            s1_thr    <= '0;
            s1_mode   <= '0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s2_border <= 1'b1;
            s2_thr    <= '0;
            s2_grey   <= 1'b0;
            s2_mag    <= '0;
        end else begin
            s0_border <= border;
            s0_thr    <= thr_lat;
            s0_mode   <= mode_lat;
            s1_border <= s0_border;
            s1_thr    <= s0_thr;
            s1_mode   <= s0_mode;
            s1_gx     <= abs_diff(gx_pos, gx_neg);
            s1_gy     <= abs_diff(gy_pos, gy_neg);
            s2_border <= s1_border;
            s2_thr    <= s1_thr;
            s2_grey   <= s1_mode[MODE_GREY];
            if (s1_mode[MODE_MAX]) begin
                s2_mag <= MAG_W'((s1_gx >= s1_gy) ? s1_gx : s1_gy);
            end else begin
                s2_mag <= MAG_W'(s1_gx) + MAG_W'(s1_gy);
            end
        end
    end

    // S3 decision: non-edge is white in binary mode and black in grey mode
    always_comb begin
        result = '0;
        if (s2_grey) begin
            if (s2_border) begin
                result = '0;
            end else if (|s2_mag[MAG_W-1:DATA_WIDTH]) begin
                result = '1;
            end else begin
                result = s2_mag[DATA_WIDTH-1:0];
            end
        end else begin
            result = (s2_border || s2_mag <= s2_thr) ? '1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_out <= '0;
        end else if (qd[SOBEL_LAT-2].valid) begin
            edge_out <= result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SOBEL_LAT; i++) begin
                qd[i] <= '0;
            end
        end else begin
            qd[0] <= '{valid: din_valid, hsync: din_hsync, vsync: din_vsync};
            for (int i = 1; i < SOBEL_LAT; i++) begin
                qd[i] <= qd[i-1];
            end
        end
    end

    assign edge_valid = qd[SOBEL_LAT-1].valid;
    assign edge_hsync = qd[SOBEL_LAT-1].hsync;
    assign edge_vsync = qd[SOBEL_LAT-1].vsync;

endmodule

// File: tb/tb_sobel_edge_ext.sv
// Scoreboard bench for sobel_edge_ext on an 8x6 frame with directed images.
module tb_sobel_edge_ext;
    import sobel_pkg::*;

    localparam int IW = 8;
    localparam int NR = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  din;
    logic        din_valid, din_hsync, din_vsync;
    logic [10:0] threshold;
    logic [1:0]  mode;
    logic [7:0]  edge_out;
    logic        edge_valid, edge_hsync, edge_vsync;

    typedef struct {
        int exp_v;
        int r;
        int c;
    } exp_t;

    exp_t     exp_q[$];
    int       img [NR][IW];
    int       cap [NR][IW];
    logic [2:0] hist [SOBEL_LAT];
    int       n_checks = 0;
    int       n_fail = 0;
    int       valid_cnt = 0;
    int       f_thr = 50;
    int       f_mode = 0;

    sobel_edge_ext #(
        .DATA_WIDTH        (8),
        .IMG_WIDTH         (IW),
        .DEFAULT_THRESHOLD (50)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_hsync  (din_hsync),
        .din_vsync  (din_vsync),
        .threshold  (threshold),
        .mode       (mode),
        .edge_out   (edge_out),
        .edge_valid (edge_valid),
        .edge_hsync (edge_hsync),
        .edge_vsync (edge_vsync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference result for the window whose newest pixel is (r, c)
    function automatic int model(input int r, input int c);
        int gx, gy, mag;
        if (r < 2 || c < 2) return (f_mode % 2 == 1) ? 0 : 255;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        gx = iabs(gx);
        gy = iabs(gy);
        mag = (f_mode >= 2) ? ((gx > gy) ? gx : gy) : gx + gy;
        if (f_mode % 2 == 1) return (mag > 255) ? 255 : mag;
        return (mag > f_thr) ? 0 : 255;
    endfunction

    // Monitor: qualifier delay, reset values and scoreboard pops
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            check("reset_outputs", int'({edge_out, edge_valid, edge_hsync, edge_vsync}), 0);
            exp_q.delete();
            for (int i = 0; i < SOBEL_LAT; i++) hist[i] = '0;
        end else begin
            for (int i = SOBEL_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {din_valid, din_hsync, din_vsync};
            check("qualifier_delay", int'({edge_valid, edge_hsync, edge_vsync}),
                  int'(hist[SOBEL_LAT-1]));
            if (edge_valid) begin
                valid_cnt++;
                check("expected_available", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    cap[e.r][e.c] = int'(edge_out);
                    if (int'(edge_out) != e.exp_v)
                        $display("  at pixel row %0d col %0d", e.r, e.c);
                    check("edge_out", int'(edge_out), e.exp_v);
                end
            end
        end
    end

    task automatic drive_px(input int r, input int c);
        exp_t e;
        @(negedge clk);
        din       = 8'(img[r][c]);
        din_valid = 1'b1;
        din_hsync = 1'b1;
        din_vsync = 1'b1;
        e.exp_v = model(r, c);
        e.r = r;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic line_gap();
        repeat (3) begin
            @(negedge clk);
            din_valid = 1'b0;
            din_hsync = 1'b0;
        end
    endtask

    task automatic frame_start(input int thr, input int md);
        @(negedge clk);
        din_valid = 1'b0;
        din_hsync = 1'b0;
        din_vsync = 1'b0;
        threshold = 11'(thr);
        mode      = 2'(md);
        repeat (3) @(negedge clk);
        f_thr = thr;
        f_mode = md;
        valid_cnt = 0;
    endtask

    task automatic run_frame(input int thr, input int md, input int gap_row,
                             input int switch_row, input int new_thr);
        frame_start(thr, md);
        for (int r = 0; r < NR; r++) begin
            if (r == switch_row) threshold = 11'(new_thr);
            for (int c = 0; c < IW; c++) begin
                drive_px(r, c);
                if (r == gap_row && c == 3) begin
                    @(negedge clk);
                    din_valid = 1'b0;
                end
            end
            line_gap();
        end
        @(negedge clk);
        din_vsync = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_queue", exp_q.size(), 0);
        check("valid_count", valid_cnt, NR * IW);
    endtask

    task automatic set_flat(input int v);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < IW; c++) img[r][c] = v;
    endtask

    task automatic set_step();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < IW; c++) img[r][c] = (c < 4) ? 0 : 255;
    endtask

    task automatic set_diag();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < IW; c++) img[r][c] = (50*(r+c) > 255) ? 255 : 50*(r+c);
    endtask

    task automatic set_bound(input int a, input int b);
        set_flat(0);
        img[1][2] = a;
        img[2][2] = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        din_hsync = 1'b0;
        din_vsync = 1'b0;
        threshold = 11'd50;
        mode = 2'd0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < IW; c++) cap[r][c] = -1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Flat frame with a mid-line valid gap: everything non-edge
        set_flat(100);
        run_frame(50, 0, 3, -1, 0);
        check("flat_interior", cap[4][5], 255);

        // Vertical step, binary
        set_step();
        run_frame(50, 0, 2, -1, 0);
        check("step_bin_c4", cap[3][4], 0);
        check("step_bin_c5", cap[3][5], 0);
        check("step_bin_flat", cap[3][6], 255);
        check("step_bin_border_row", cap[1][4], 255);
        check("step_bin_border_col", cap[4][1], 255);

        // Vertical step, grey L1
        run_frame(50, 1, -1, -1, 0);
        check("step_grey_sat", cap[3][4], 255);
        check("step_grey_flat", cap[3][6], 0);
        check("step_grey_border", cap[0][5], 0);

        // Diagonal ramp: Gx=Gy=400 at (2,2)
        set_diag();
        run_frame(600, 0, -1, -1, 0);
        check("diag_l1", cap[2][2], 0);
        run_frame(600, 2, -1, -1, 0);
        check("diag_max", cap[2][2], 255);

        // Threshold boundary in max norm: 50 vs 51
        set_bound(12, 26);
        run_frame(50, 2, -1, -1, 0);
        check("thr_equal", cap[2][2], 255);
        set_bound(13, 25);
        run_frame(50, 2, -1, -1, 0);
        check("thr_above", cap[2][2], 0);

        // Mid-frame threshold change only applies from the next frame
        set_step();
        run_frame(50, 0, -1, 2, 2000);
        check("thr_frozen", cap[4][4], 0);
        run_frame(2000, 0, -1, -1, 0);
        check("thr_next_frame", cap[4][4], 255);

        // Reset pulse mid-line, then a clean frame
        set_flat(100);
        frame_start(50, 0);
        for (int c = 0; c < IW; c++) drive_px(0, c);
        line_gap();
        for (int c = 0; c < 4; c++) drive_px(1, c);
        @(negedge clk);
        reset_n = 1'b0;
        din_valid = 1'b0;
        din_hsync = 1'b0;
        din_vsync = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_flush", exp_q.size(), 0);
        set_step();
        run_frame(50, 0, -1, -1, 0);
        check("post_reset_edge", cap[5][5], 0);
        check("post_reset_flat", cap[5][7], 255);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge_ext.md
# sobel_edge_ext

Parametrised Sobel edge detector for the grey-scale video path, placed after the median filter and before the binary/overlay stages. It builds a 3x3 window from a synchronous pixel stream using an internal two-line buffer and computes Sobel Gx/Gy. Output is either a binary edge map or a saturated grey-level gradient magnitude, with a selectable L1 or max norm. Threshold and mode are run-time inputs latched per frame, and frame-border pixels are forced to "non-edge".

## Interface
- DATA_WIDTH, 8: pixel bit width.
- IMG_WIDTH, 640: active pixels per line; sets line-buffer depth and column-counter range.
- DEFAULT_THRESHOLD, 50: threshold value held from reset until the first frame latch.
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  grey pixel.
- din_valid  in  1  pixel qualifier.
- din_hsync  in  1  line active, high during a line.
- din_vsync  in  1  frame active, high during a frame.
- threshold  in  DATA_WIDTH+3  magnitude threshold.
- mode  in  2  mode[0]: 0 = binary, 1 = grey magnitude; mode[1]: 0 = L1 |Gx|+|Gy|, 1 = max(|Gx|,|Gy|).
- edge_out  out  DATA_WIDTH  result pixel.
- edge_valid, edge_hsync, edge_vsync  out  1 each  delayed qualifiers.

## Operation
- Magnitude width MAG_W = DATA_WIDTH+3, so the L1 maximum 8*(2^DATA_WIDTH-1) never overflows. Each |G| is DATA_WIDTH+2 bits, unsigned, computed as larger-sum minus smaller-sum. No signed arithmetic.
- Window shifts only on din_valid=1 while din_hsync=1 and din_vsync=1. When din_hsync=0, all window registers clear to 0.
- Line buffer writes din on every qualified pixel. It is read at the same address, giving the rows one line and two lines old.
- col_cnt counts qualified pixels in a line and clears while din_hsync=0. row_cnt increments when a qualified pixel arrives with col_cnt=IMG_WIDTH-1, and clears while din_vsync=0. Neither counter wraps past IMG_WIDTH-1 or 2047.
- Border: if the pixel entering the window has col_cnt<2 or row_cnt<2, the result is forced to non-edge.
- Binary mode: edge_out = 0 (black) when mag > thr_lat, otherwise all-ones. mag == thr_lat counts as non-edge.
- Grey mode: edge_out = min(mag, 2^DATA_WIDTH-1). A forced non-edge border pixel outputs 0.
- thr_lat and mode_lat load from the threshold and mode inputs while din_vsync=0, and freeze when din_vsync=1. A mid-frame change takes effect on the next frame.

## Timing
- Reset values: edge_out=0, edge_valid=0, edge_hsync=0, edge_vsync=0. Counters and window are 0, thr_lat=DEFAULT_THRESHOLD, mode_lat=0.
- The pipeline runs freely with no stall. Stages:
  - S0: window load.
  - S1: |Gx| and |Gy| registers.
  - S2: norm select.
  - S3: threshold, saturate and border mux into edge_out.
- Latency: edge_valid, edge_hsync and edge_vsync equal din_valid, din_hsync and din_vsync delayed by exactly 4 clocks.
- The edge_out presented with edge_valid=1 is the result for the window whose newest pixel arrived 4 clocks earlier.
- edge_out changes only on cycles where the delayed valid is 1. Otherwise it holds its previous value.
- If reset_n is asserted mid-frame, all state clears immediately. The stream restarts cleanly at the next din_vsync rising edge.

## Structure
- Package sobel_pkg holds:
  - mode bit positions MODE_GREY=0 and MODE_MAX=1;
  - function mag_width(DATA_WIDTH) = DATA_WIDTH+3;
  - pipeline latency constant SOBEL_LAT=4.
- Sub-module sobel_line_buffer (DATA_WIDTH, IMG_WIDTH). It is a two-tap RAM delay line with an internal write/read pointer that wraps at IMG_WIDTH-1, and it exposes taps1x and taps0x.
- The top module contains the counters, window, pipeline and qualifier delay lines. Target size is roughly 200-300 lines in total.

## Test plan
- Flat frame, IMG_WIDTH=8, 6 lines, all pixels 100, threshold=50, mode=0 -> every edge_out=0xFF; edge_valid count = 48; qualifiers delayed 4 clocks.
- Vertical step, columns 0-3 = 0 and columns 4-7 = 255, mode=0, threshold=50 -> interior pixels whose window spans the step give |Gx|=1020 and edge_out=0x00; other pixels give 0xFF; rows 0-1 and columns 0-1 give 0xFF (border).
- Same step with mode=1 (grey, L1) -> spanning pixels give 0xFF (saturated from 1020); flat interior gives 0; border gives 0.
- Diagonal window with Gx=Gy=400, threshold=600 -> mode=0 gives 0x00 (800>600); mode=2 (max norm) gives 0xFF (400≤600).
- Threshold boundary: window mag exactly 50 with thr=50 -> 0xFF; mag 51 -> 0x00.
- Change threshold mid-frame from 50 to 2000 -> the current frame still uses 50 and the next frame uses 2000. Separately, pulse reset_n low mid-line -> all outputs read 0 next cycle and the following frame is correct.
